// File: rtl/gat_pkg.sv
// Shared types and default sizing for the GAT feature stream-out slice.
// The top-level parameters default to these constants so both stay consistent.
package gat_pkg;

  localparam int NEW_FEATURE_WIDTH  = 32;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } gat_state_e;

  typedef struct packed {
    logic [NEW_FEATURE_WIDTH-1:0] data;
    logic                         user;
    logic                         last;
  } feat_entry_t;

  // Travels alongside an outstanding BRAM read until its data returns.
  typedef struct packed {
    logic valid;
    logic user;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/gat_sync_fifo.sv
// Small synchronous FIFO with a head read straight from flop storage.
// Push and pop may happen in the same cycle; the caller guarantees no overflow.
module gat_sync_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset so the head reads 0 out of reset; fine at this depth, not for a real RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(DEPTH)) && !pop_ok));

endmodule

// File: rtl/gat_feat_stream_out.sv
// Sweeps the new-feature BRAM once per gat_ready rising edge and streams every word
// over AXI4-Stream, using read credits so the prefetch FIFO can never overflow.
module gat_feat_stream_out #(
  parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
  parameter int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);
  import gat_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX  = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [FEAT_W-1:0]             LAST_FEAT = FEAT_W'(NUM_FEATURE_OUT - 1);

  gat_state_e                    state_q, state_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          gat_ready_q;
  logic [NEW_FEATURE_ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [FEAT_W-1:0]             feat_cnt_q, feat_cnt_d;
  rd_tag_t                       tag_q [RD_LATENCY];
  rd_tag_t                       tag_d [RD_LATENCY];

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   occupancy;
  logic             start, issue, fifo_push, fifo_pop, fifo_empty;
  feat_entry_t      fifo_wdata, fifo_head;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_idx_d   = rd_idx_q;
    feat_cnt_d = feat_cnt_q;

    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(tag_q[i].valid);
    occupancy = {1'b0, fifo_count} + {1'b0, inflight};

    start    = (state_q == IDLE) && gat_ready && !gat_ready_q;
    issue    = (state_q == READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    fifo_pop = m_axis_tvalid && m_axis_tready;

    case (state_q)
      IDLE: if (start) begin
        state_d    = READ;
        busy_d     = 1'b1;
        rd_idx_d   = '0;
        feat_cnt_d = '0;
      end
      READ: if (issue) begin
        feat_cnt_d = (feat_cnt_q == LAST_FEAT) ? '0 : feat_cnt_q + FEAT_W'(1);
        if (rd_idx_q == LAST_IDX) state_d  = DRAIN;
        else                      rd_idx_d = rd_idx_q + NEW_FEATURE_ADDR_W'(1);
      end
      // Leave as soon as the final beat handshakes so done follows it by one cycle.
      DRAIN: if ((inflight == '0) &&
                 (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d    = IDLE;
        rd_idx_d   = '0;
        feat_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    tag_d[0] = '{valid: issue,
                 user:  issue && (feat_cnt_q == '0),
                 last:  issue && (rd_idx_q == LAST_IDX)};
    for (int i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];

    fifo_push  = tag_q[RD_LATENCY-1].valid;
    fifo_wdata = '{data: feat_bram_dout,
                   user: tag_q[RD_LATENCY-1].user,
                   last: tag_q[RD_LATENCY-1].last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      // A level already high when reset releases must not look like a fresh edge.
      gat_ready_q <= 1'b1;
      rd_idx_q    <= '0;
      feat_cnt_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gat_ready_q <= gat_ready;
      rd_idx_q    <= rd_idx_d;
      feat_cnt_q  <= feat_cnt_d;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  gat_sync_fifo #(
    .WIDTH ($bits(feat_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign feat_bram_addrb = {rd_idx_q, 2'b00};
  assign m_axis_tvalid   = !fifo_empty;
  assign m_axis_tdata    = fifo_head.data;
  assign m_axis_tuser    = fifo_head.user;
  assign m_axis_tlast    = fifo_head.last;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
